thermo_dac_driver: RTL and testbench

- Reverse path of the flash-ADC priority encoder: accepts a CODE_W-bit binary code and drives a bubble-free thermometer code out of the board's GPIO pins into an external resistor-string DAC.
- Each code is held for a programmable settle time before the next code is accepted.
- Also drives the current code to the onboard LEDs, so the ADC loop-back (DAC -> comparators -> encoder) can be checked by eye.

---
 rtl/thermo_dac_driver.sv | 149 ++++++++++++++
 tb/tb_thermo_dac_driver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/thermo_dac_driver.sv
// Binary-to-thermometer DAC driver: holds each accepted code for SETTLE_CYCLES before taking the next.
// Optional slew limiting (one LSB per settle period) is built when THERMO_DAC_SLEW_LIMIT_EN is defined.
module thermo_dac_driver #(
  parameter int CODE_W        = 3,
  parameter int SETTLE_CYCLES = 125,
  localparam int TH_W         = 2**CODE_W - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [TH_W-1:0]   therm_out,
  output logic [CODE_W-1:0] cur_code,
  output logic              busy,
  output logic              settle_done
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

`ifdef THERMO_DAC_SLEW_LIMIT_EN
  typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETTLE} state_t;
`endif

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CODE_W-1:0] target, target_n;
  logic [CODE_W-1:0] cur_n;
  logic [TH_W-1:0]   therm_n;
  logic              ready_n, busy_n, done_n;
`ifndef THERMO_DAC_SLEW_LIMIT_EN
  logic              load, load_n;
`endif

  function automatic logic [TH_W-1:0] to_therm(input logic [CODE_W-1:0] code);
    logic [TH_W-1:0] t;
    for (int i = 0; i < TH_W; i++) t[i] = (int'(code) > i);
    return t;
  endfunction

`ifdef THERMO_DAC_SLEW_LIMIT_EN
  function automatic logic [CODE_W-1:0] step_toward(input logic [CODE_W-1:0] cur,
                                                    input logic [CODE_W-1:0] tgt);
    if (cur < tgt)      return cur + CODE_W'(1);
    else if (cur > tgt) return cur - CODE_W'(1);
    else                return cur;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      target      <= '0;
      cur_code    <= '0;
      therm_out   <= '0;
      code_ready  <= 1'b0;
      busy        <= 1'b0;
      settle_done <= 1'b0;
`ifndef THERMO_DAC_SLEW_LIMIT_EN
      load        <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      target      <= target_n;
      cur_code    <= cur_n;
      therm_out   <= therm_n;
      code_ready  <= ready_n;
      busy        <= busy_n;
      settle_done <= done_n;
`ifndef THERMO_DAC_SLEW_LIMIT_EN
      load        <= load_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    target_n = target;
    cur_n    = cur_code;
    ready_n  = code_ready;
    busy_n   = busy;
    done_n   = 1'b0;
`ifndef THERMO_DAC_SLEW_LIMIT_EN
    load_n   = load;
`endif
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (code_valid && code_ready) begin
          target_n = code_in;
          ready_n  = 1'b0;
          busy_n   = 1'b1;
          cnt_n    = '0;
`ifdef THERMO_DAC_SLEW_LIMIT_EN
          state_n  = STEP;
`else
          state_n  = SETTLE;
          load_n   = 1'b1;
`endif
        end
      end
`ifdef THERMO_DAC_SLEW_LIMIT_EN
      STEP: begin
        cur_n   = step_toward(cur_code, target);
        cnt_n   = '0;
        state_n = SETTLE;
      end
`endif
      SETTLE: begin
`ifndef THERMO_DAC_SLEW_LIMIT_EN
        // First SETTLE cycle only transfers the latched target onto the pins.
        if (load) begin
          cur_n  = target;
          cnt_n  = '0;
          load_n = 1'b0;
        end else
`endif
        if (cnt == CNT_LAST) begin
`ifdef THERMO_DAC_SLEW_LIMIT_EN
          // Intermediate steps chain straight into the next hold period.
          if (cur_code != target) begin
            cur_n = step_toward(cur_code, target);
            cnt_n = '0;
          end else
`endif
          begin
            done_n  = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    therm_n = to_therm(cur_n);
  end

endmodule

// File: tb/tb_thermo_dac_driver.sv
// Directed bench for thermo_dac_driver with SETTLE_CYCLES=4, CODE_W=3.
module tb_thermo_dac_driver;

  localparam int CODE_W = 3;
  localparam int SC     = 4;
  localparam int TH_W   = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CODE_W-1:0] code_in = '0;
  logic              code_valid = 1'b0;
  logic              code_ready;
  logic [TH_W-1:0]   therm_out;
  logic [CODE_W-1:0] cur_code;
  logic              busy;
  logic              settle_done;

  int tests = 0;
  int failed = 0;

  thermo_dac_driver #(.CODE_W(CODE_W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .therm_out(therm_out), .cur_code(cur_code),
    .busy(busy), .settle_done(settle_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full accept/settle sequence starting from a code_ready=1 cycle.
  task automatic run_code(input logic [CODE_W-1:0] code, input logic [TH_W-1:0] exp_th,
                          input logic [TH_W-1:0] prev_th);
    int busy_cnt;
    chk("pre_ready", 32'(code_ready), 32'd1);
    code_in = code;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("acc_ready", 32'(code_ready), 32'd0);
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_therm_hold", 32'(therm_out), 32'(prev_th));
    chk("acc_done", 32'(settle_done), 32'd0);
    busy_cnt = 1;
    tick();
    chk("load_therm", 32'(therm_out), 32'(exp_th));
    chk("load_cur", 32'(cur_code), 32'(code));
    for (int k = 1; k <= SC; k++) begin
      if (busy) busy_cnt++;
      tick();
      chk("hold_therm", 32'(therm_out), 32'(exp_th));
      chk("hold_done", 32'(settle_done), (k == SC) ? 32'd1 : 32'd0);
    end
    chk("end_ready", 32'(code_ready), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("busy_cycles", 32'(busy_cnt), 32'(SC + 1));
  endtask

  initial begin
    int acc [2];
    int nacc, ndone;
    logic [TH_W-1:0] th0, th1;
    logic pr;

    // Reset state
    #12;
    chk("rst_therm", 32'(therm_out), 32'd0);
    chk("rst_cur", 32'(cur_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(code_ready), 32'd0);
    chk("rst_done", 32'(settle_done), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(code_ready), 32'd0);
    tick();
    chk("ready_after_release", 32'(code_ready), 32'd1);

`ifndef THERMO_DAC_SLEW_LIMIT_EN
    // Basic code, then the range extremes
    run_code(3'd3, 7'b0000111, 7'b0000000);
    run_code(3'd0, 7'b0000000, 7'b0000111);
    run_code(3'd7, 7'b1111111, 7'b0000000);

    // Back-to-back with valid held high
    nacc = 0; ndone = 0; th0 = '0; th1 = '0;
    acc[0] = 0; acc[1] = 0;
    code_in = 3'd5;
    code_valid = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      pr = code_ready;
      tick();
      if (nacc >= 1 && cyc == acc[0] + 1) th0 = therm_out;
      if (nacc >= 2 && cyc == acc[1] + 1) th1 = therm_out;
      if (pr && code_valid && !code_ready && nacc < 2) begin
        acc[nacc] = cyc;
        nacc++;
        if (nacc == 1) code_in = 3'd1;
        else code_valid = 1'b0;
      end
      if (settle_done) ndone++;
    end
    chk("b2b_accepts", 32'(nacc), 32'd2);
    chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'(SC + 2));
    chk("b2b_therm5", 32'(th0), 32'h1F);
    chk("b2b_therm1", 32'(th1), 32'h01);
    chk("b2b_dones", 32'(ndone), 32'd2);
    chk("b2b_ready", 32'(code_ready), 32'd1);

    // Reset two cycles into SETTLE
    code_in = 3'd6;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    chk("abort_load", 32'(therm_out), 32'h3F);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_therm", 32'(therm_out), 32'd0);
    chk("abort_cur", 32'(cur_code), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (settle_done) ndone++;
    end
    rst_n = 1'b1;
    tick();
    if (settle_done) ndone++;
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_ready", 32'(code_ready), 32'd1);

    // Repeated identical code
    run_code(3'd4, 7'b0001111, 7'b0000000);
    run_code(3'd4, 7'b0001111, 7'b0001111);
`else
    // Slew-limited stepping from 1 to 4
    run_code(3'd1, 7'b0000001, 7'b0000000);
    code_in = 3'd4;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("slew_acc_ready", 32'(code_ready), 32'd0);
    ndone = 0;
    for (int cyc = 1; cyc <= 3 * SC; cyc++) begin
      tick();
      chk("slew_cur", 32'(cur_code), 32'(2 + (cyc - 1) / SC));
      chk("slew_ready", 32'(code_ready), 32'd0);
      if (settle_done) ndone++;
    end
    chk("slew_no_early_done", 32'(ndone), 32'd0);
    tick();
    chk("slew_done", 32'(settle_done), 32'd1);
    chk("slew_end_ready", 32'(code_ready), 32'd1);
    chk("slew_therm", 32'(therm_out), 32'h0F);
`endif

    tick();
    chk("final_done_low", 32'(settle_done), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
